// File: rtl/cov_stall_monitor.sv
// Coverage-progress monitor: flags a stall when every enabled coverage channel stops
// moving, or a watchdog timeout when the test never signals completion on tohost[0].
module cov_stall_monitor #(
   parameter int NCH         = 2,
   parameter int COV_W       = 30,
   parameter int CNT_W       = 32,
   parameter int STALL_LIMIT = 1000,
   parameter int WDOG_LIMIT  = 10000,
   parameter int HOLDOFF     = 16,
   parameter int PULSE_MODE  = 0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NCH*COV_W-1:0] cov,
   input  logic [NCH-1:0]       ch_en,
   input  logic [63:0]          tohost,
   input  logic                 irq_ack,
   output logic                 interrupt,
   output logic [1:0]           irq_cause,
   output logic [NCH-1:0]       stall_mask,
   output logic [15:0]          irq_count
);

   typedef enum logic [1:0] {MON = 2'd0, ASSERT = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_LIMIT);
   localparam logic [CNT_W-1:0] WDOG_LIM  = CNT_W'(WDOG_LIMIT);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

   state_t           state;
   logic [COV_W-1:0] pre_cov [NCH];
   logic [CNT_W-1:0] idle    [NCH];
   logic [CNT_W-1:0] wdog;
   logic [CNT_W-1:0] hold_cnt;
   logic             done;
   logic             stall;
   logic             all_idle;
   logic             wdog_trip;
   logic             go_hold;
   logic             unused_tohost;

   assign done          = tohost[0];
   assign unused_tohost = ^tohost[63:1];
   assign wdog_trip     = (wdog >= WDOG_LIM);
   // Completion outranks the acknowledge, so HOLD entry is suppressed while done is high.
   assign go_hold       = (state == ASSERT) && ((PULSE_MODE != 0) || irq_ack) && !done;

   always_comb begin
      all_idle   = 1'b1;
      stall_mask = '0;
      for (int i = 0; i < NCH; i++) begin
         stall_mask[i] = ch_en[i] && (idle[i] >= STALL_LIM);
         if (ch_en[i] && (idle[i] < STALL_LIM)) all_idle = 1'b0;
      end
      stall = (|ch_en) && all_idle;
   end

   // Per-channel progress tracking; disabled channels shadow cov so re-enabling starts clean.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            pre_cov[i] <= '0;
            idle[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!ch_en[i] || go_hold) begin
               pre_cov[i] <= cov[i*COV_W +: COV_W];
               idle[i]    <= '0;
            end else if (done) begin
               idle[i] <= '0;
            end else if (state == MON) begin
               if (cov[i*COV_W +: COV_W] != pre_cov[i]) begin
                  pre_cov[i] <= cov[i*COV_W +: COV_W];
                  idle[i]    <= '0;
               end else begin
                  idle[i] <= sat_inc(idle[i]);
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n)                wdog <= '0;
      else if (done || go_hold)    wdog <= '0;
      else if (state == MON)       wdog <= sat_inc(wdog);
   end

   // Interrupt FSM; interrupt is registered alongside the ASSERT state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= MON;
         interrupt <= 1'b0;
         irq_cause <= 2'b00;
         irq_count <= 16'd0;
         hold_cnt  <= '0;
      end else if (done) begin
         state     <= MON;
         interrupt <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            MON: begin
               if (stall || wdog_trip) begin
                  state     <= ASSERT;
                  interrupt <= 1'b1;
                  irq_cause <= {wdog_trip, stall};
                  irq_count <= sat_inc16(irq_count);
               end
            end
            ASSERT: begin
               if (go_hold) begin
                  state     <= HOLD;
                  interrupt <= 1'b0;
                  hold_cnt  <= '0;
               end
            end
            HOLD: begin
               if (hold_cnt >= HOLD_LAST) state <= MON;
               else                       hold_cnt <= sat_inc(hold_cnt);
            end
            default: begin
               state     <= MON;
               interrupt <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cov_stall_monitor.sv
// Bench for cov_stall_monitor: a short-limit instance driven from a vector table, plus
// default-limit level and pulse instances exercised with long directed sequences.
module tb_cov_stall_monitor;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   // Shared stimulus for the default-parameter level and pulse instances.
   logic        reset_n = 1'b0;
   logic [59:0] cov     = '0;
   logic [1:0]  ch_en   = 2'b11;
   logic [63:0] tohost  = '0;
   logic        irq_ack = 1'b0;
   logic        l_int, p_int;
   logic [1:0]  l_cause, p_cause, l_mask, p_mask;
   logic [15:0] l_cnt, p_cnt;

   // Stimulus for the short-limit instance.
   logic        s_rst_n = 1'b0;
   logic [15:0] s_cov   = '0;
   logic [1:0]  s_en    = 2'b11;
   logic [63:0] s_tohost = '0;
   logic        s_ack   = 1'b0;
   logic        s_int;
   logic [1:0]  s_cause, s_mask;
   logic [15:0] s_cnt;

   cov_stall_monitor #(.PULSE_MODE(0)) u_lvl (
      .clock(clock), .reset_n(reset_n), .cov(cov), .ch_en(ch_en), .tohost(tohost),
      .irq_ack(irq_ack), .interrupt(l_int), .irq_cause(l_cause), .stall_mask(l_mask),
      .irq_count(l_cnt));

   cov_stall_monitor #(.PULSE_MODE(1)) u_pls (
      .clock(clock), .reset_n(reset_n), .cov(cov), .ch_en(ch_en), .tohost(tohost),
      .irq_ack(irq_ack), .interrupt(p_int), .irq_cause(p_cause), .stall_mask(p_mask),
      .irq_count(p_cnt));

   cov_stall_monitor #(.NCH(2), .COV_W(8), .CNT_W(8), .STALL_LIMIT(3), .WDOG_LIMIT(12),
                       .HOLDOFF(2), .PULSE_MODE(0)) u_sml (
      .clock(clock), .reset_n(s_rst_n), .cov(s_cov), .ch_en(s_en), .tohost(s_tohost),
      .irq_ack(s_ack), .interrupt(s_int), .irq_cause(s_cause), .stall_mask(s_mask),
      .irq_count(s_cnt));

   typedef struct packed {
      logic        rst_n;
      logic [15:0] cov;
      logic [1:0]  en;
      logic        th;
      logic        ack;
      logic        e_int;
      logic [1:0]  e_cause;
      logic [1:0]  e_mask;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [16];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Counts cycles until the level instance raises interrupt; 0 means it never did.
   task automatic wait_lint(output int n);
      n = 0;
      for (int c = 1; c <= 1100; c++) begin
         step();
         if (l_int === 1'b1) begin
            n = c;
            break;
         end
      end
   endtask

   initial begin
      int bad_a, bad_b, n;
      logic exp_l, exp_p;

      // rst  cov      en    th    ack   int   cause  mask   count
      tbl[0]  = '{1'b0, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0};
      tbl[1]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0};
      tbl[2]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0};
      tbl[3]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 16'd0};
      tbl[4]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 16'd1};
      tbl[5]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 2'b11, 16'd1};
      tbl[6]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 16'd1};
      tbl[7]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd1};
      tbl[8]  = '{1'b1, 16'h0000, 2'b11, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 16'd1};
      tbl[9]  = '{1'b1, 16'h0005, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd1};
      tbl[10] = '{1'b1, 16'h0005, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd1};
      tbl[11] = '{1'b1, 16'h0005, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 16'd1};
      tbl[12] = '{1'b1, 16'h0006, 2'b11, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 16'd1};
      tbl[13] = '{1'b1, 16'h0006, 2'b10, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 16'd2};
      tbl[14] = '{1'b1, 16'h0006, 2'b10, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 16'd2};
      tbl[15] = '{1'b1, 16'h0006, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd2};

      for (int k = 0; k < 16; k++) begin
         s_rst_n  = tbl[k].rst_n;
         s_cov    = tbl[k].cov;
         s_en     = tbl[k].en;
         s_tohost = {63'd0, tbl[k].th};
         s_ack    = tbl[k].ack;
         step();
         chk($sformatf("tbl%0d interrupt", k), s_int, tbl[k].e_int);
         chk($sformatf("tbl%0d irq_cause", k), s_cause, tbl[k].e_cause);
         chk($sformatf("tbl%0d stall_mask", k), s_mask, tbl[k].e_mask);
         chk($sformatf("tbl%0d irq_count", k), s_cnt, tbl[k].e_cnt);
      end

      // Short instance: watchdog with no channels enabled, then a simultaneous trip.
      bad_a = 0;
      for (int c = 0; c < 11; c++) begin
         step();
         if (s_int !== 1'b0) bad_a++;
      end
      chk("sml wdog early irq cycles", bad_a, 0);
      step();
      chk("sml wdog interrupt", s_int, 1'b1);
      chk("sml wdog cause", s_cause, 2'b10);
      chk("sml wdog count", s_cnt, 16'd3);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      chk("sml ack drop", s_int, 1'b0);
      step();
      step();
      chk("sml hold no irq", s_int, 1'b0);
      chk("sml cause held", s_cause, 2'b10);
      for (int c = 0; c < 9; c++) step();
      s_en = 2'b11;
      for (int c = 0; c < 3; c++) step();
      chk("sml both pre mask", s_mask, 2'b11);
      chk("sml both pre irq", s_int, 1'b0);
      step();
      chk("sml both interrupt", s_int, 1'b1);
      chk("sml both cause", s_cause, 2'b11);
      chk("sml both count", s_cnt, 16'd4);

      // Default instances: reset state.
      reset_n = 1'b0;
      step();
      step();
      chk("rst lvl interrupt", l_int, 1'b0);
      chk("rst lvl cause", l_cause, 2'b00);
      chk("rst lvl count", l_cnt, 16'd0);
      chk("rst lvl mask", l_mask, 2'b00);
      chk("rst pls interrupt", p_int, 1'b0);

      // Stall trip, level handshake after 20 cycles, pulse mode single cycle and holdoff.
      tohost  = 64'h8000_0000_0000_0000;
      reset_n = 1'b1;
      bad_a = 0;
      bad_b = 0;
      for (int t = 1; t <= 2039; t++) begin
         irq_ack = (t == 1022);
         step();
         exp_l = ((t >= 1001) && (t <= 1021)) || (t >= 2039);
         exp_p = (t == 1001) || (t == 2019);
         if (l_int !== exp_l) begin
            if (bad_a == 0) $display("lvl interrupt first deviation at cycle %0d", t);
            bad_a++;
         end
         if (p_int !== exp_p) begin
            if (bad_b == 0) $display("pls interrupt first deviation at cycle %0d", t);
            bad_b++;
         end
         if (t == 1000) chk("stall mask at 1000", l_mask, 2'b11);
         if (t == 1001) begin
            chk("stall cause", l_cause, 2'b01);
            chk("stall count lvl", l_cnt, 16'd1);
            chk("stall count pls", p_cnt, 16'd1);
         end
         if (t == 2039) begin
            chk("retrip count lvl", l_cnt, 16'd2);
            chk("retrip count pls", p_cnt, 16'd2);
         end
      end
      irq_ack = 1'b0;
      chk("lvl interrupt trace", bad_a, 0);
      chk("pls interrupt trace", bad_b, 0);

      // Completion while asserted and acked: back to MON, counts and cause untouched.
      tohost  = 64'h1;
      irq_ack = 1'b1;
      step();
      tohost  = '0;
      irq_ack = 1'b0;
      chk("tohost drop irq", l_int, 1'b0);
      chk("tohost keeps count", l_cnt, 16'd2);
      chk("tohost keeps cause", l_cause, 2'b01);
      chk("tohost clears mask", l_mask, 2'b00);
      for (int c = 0; c < 1000; c++) step();
      chk("pre-trip mask", l_mask, 2'b11);
      tohost = 64'h1;
      step();
      tohost = '0;
      chk("tohost vs trip irq", l_int, 1'b0);
      chk("tohost vs trip mask", l_mask, 2'b00);
      chk("tohost vs trip count", l_cnt, 16'd2);
      chk("tohost vs trip pls", p_int, 1'b0);

      // Reset while asserted.
      wait_lint(n);
      chk("cycles to trip after tohost", n, 1001);
      chk("count before reset", l_cnt, 16'd3);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("mid-assert reset irq", l_int, 1'b0);
      chk("mid-assert reset count", l_cnt, 16'd0);
      chk("mid-assert reset cause", l_cause, 2'b00);
      chk("mid-assert reset mask", l_mask, 2'b00);
      wait_lint(n);
      chk("cycles to trip after reset", n, 1001);

      // Channel 0 progresses every 500 cycles: only the watchdog can fire.
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      bad_a = 0;
      bad_b = 0;
      for (int t = 1; t <= 10001; t++) begin
         cov = {30'd0, 30'(t / 500)};
         step();
         if (l_mask !== ((t >= 1000) ? 2'b10 : 2'b00)) bad_a++;
         if (l_int !== (t == 10001)) bad_b++;
         if (t == 10001) begin
            chk("wdog cause", l_cause, 2'b10);
            chk("wdog count", l_cnt, 16'd1);
            chk("wdog pls interrupt", p_int, 1'b1);
         end
      end
      chk("progress mask trace", bad_a, 0);
      chk("progress interrupt trace", bad_b, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cov_stall_monitor.md
COV_STALL_MONITOR -- requirements
Module: cov_stall_monitor

Interface
REQ-001 SHALL have parameter NCH, default 2: number of coverage channels, range 1..8.
REQ-002 SHALL have parameter COV_W, default 30: width of each channel's coverage sum.
REQ-003 SHALL have parameter CNT_W, default 32: width of every counter.
REQ-004 SHALL have parameter STALL_LIMIT, default 1000: number of no-progress cycles that trips a stall.
REQ-005 SHALL have parameter WDOG_LIMIT, default 10000: number of cycles without tohost[0] that trips the watchdog.
REQ-006 SHALL have parameter HOLDOFF, default 16: number of cycles spent in HOLDOFF after an interrupt.
REQ-007 SHALL have parameter PULSE_MODE, default 0: 1 = one-cycle interrupt, 0 = level interrupt held until acknowledged.
REQ-008 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-009 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-010 SHALL have port cov, input, NCH*COV_W: coverage sums, with channel i at bits [i*COV_W +: COV_W].
REQ-011 SHALL have port ch_en, input, NCH: per-channel enable; a disabled channel is ignored.
REQ-012 SHALL have port tohost, input, 64: test-completion word; bit 0 = done.
REQ-013 SHALL have port irq_ack, input, 1: acknowledge, used in level mode only.
REQ-014 SHALL have port interrupt, output, 1: stall/watchdog interrupt.
REQ-015 SHALL have port irq_cause, output, 2: bit0 = stall, bit1 = watchdog.
REQ-016 SHALL have port stall_mask, output, NCH: per-channel flag, high while that channel's idle counter is at or above STALL_LIMIT.
REQ-017 SHALL have port irq_count, output, 16: number of interrupts raised since reset; saturates at 16'hFFFF.

Function
REQ-018 SHALL keep, per channel, a pre_cov register and a saturating idle counter idle[i] of CNT_W bits.
REQ-019 Each cycle in state MON, for each enabled channel: if cov[i] != pre_cov[i], SHALL set pre_cov[i] <= cov[i] and idle[i] <= 0; otherwise idle[i] <= idle[i]+1, saturating at all-ones.
REQ-020 A disabled channel SHALL hold idle[i] at 0 and keep pre_cov[i] tracking cov[i] every cycle.
REQ-021 stall SHALL be high when at least one channel is enabled and every enabled channel has idle[i] >= STALL_LIMIT.
REQ-022 With ch_en all zero, stall SHALL be 0.
REQ-023 SHALL keep a watchdog counter wdog of CNT_W bits, saturating; it increments every cycle in MON; wdog_trip = (wdog >= WDOG_LIMIT).
REQ-024 The FSM SHALL have three states: MON, ASSERT, HOLD.
REQ-025 In MON, when stall or wdog_trip is high, the FSM SHALL go to ASSERT next cycle, latching irq_cause = {wdog_trip, stall} and incrementing irq_count.
REQ-026 When stall and wdog_trip are high in the same cycle, both cause bits SHALL be set.
REQ-027 interrupt SHALL equal (state == ASSERT), as a registered output.
REQ-028 In ASSERT with PULSE_MODE=1, the FSM SHALL go to HOLD after exactly one cycle.
REQ-029 In ASSERT with PULSE_MODE=0, the FSM SHALL stay until irq_ack is sampled high, then go to HOLD.
REQ-030 irq_ack sampled in MON or HOLD SHALL be ignored.
REQ-031 On entry to HOLD, all idle[i] and wdog SHALL be cleared, and pre_cov[i] SHALL load cov[i].
REQ-032 HOLD SHALL last exactly HOLDOFF cycles, after which the FSM returns to MON.
REQ-033 irq_cause SHALL hold its value until the next ASSERT entry.
REQ-034 tohost[0] high in any state SHALL, next cycle: clear all idle[i] and wdog, set the FSM to MON, and deassert interrupt.
REQ-035 tohost[0] SHALL take priority over a simultaneous trip and over irq_ack.
REQ-036 tohost[0] SHALL leave irq_cause and irq_count unchanged.
REQ-037 stall_mask[i] SHALL equal ch_en[i] && (idle[i] >= STALL_LIMIT), computed combinationally from the registers.

Reset
REQ-038 While reset_n is low at a rising clock edge, the block SHALL set: state = MON, interrupt = 0, irq_cause = 0, irq_count = 0, all idle[i] = 0, wdog = 0, all pre_cov[i] = 0.
REQ-039 Consequently stall_mask SHALL read 0 during reset.
REQ-040 Reset asserted in any state, including mid-ASSERT or mid-HOLD, SHALL abort the current operation with no residual interrupt.

Verification
REQ-041 Stall trip: NCH=2, ch_en=2'b11, cov constant, tohost=0 -> interrupt rises on cycle 1001 after reset release, irq_cause=2'b01.
REQ-042 Progress keeps counters clear: channel 0 changes every 500 cycles, channel 1 constant -> stall_mask=2'b10 from cycle 1000, interrupt stays 0 until the watchdog trips at cycle 10000 with irq_cause=2'b10.
REQ-043 Level mode handshake: after a trip, irq_ack is held low 20 cycles, then pulsed 1 cycle -> interrupt stays high for all 20 cycles, falls the cycle after the ack, and the FSM re-enters MON after 16 HOLD cycles.
REQ-044 Pulse mode: PULSE_MODE=1, stall trip -> interrupt high for exactly 1 cycle, irq_count=1, and no re-trip before HOLDOFF + STALL_LIMIT cycles.
REQ-045 tohost priority: tohost[0]=1 in the same cycle stall trips -> no ASSERT, counters read 0, irq_count unchanged.
REQ-046 Reset mid-ASSERT: reset_n pulled low for 1 cycle while interrupt=1 -> interrupt=0, irq_count=0, state=MON.
